sync_fifo: RTL

Single-clock synchronous FIFO. It is the device-under-test side of the FIFO write/read port protocol that the FIFO stimulus generator/checker drives.
- Accepts words on a write port gated by full.
- Returns them in order on a read port gated by empty.
- Reports overflow/underflow attempts.
- Used as the baseline buffer in bench and core datapaths.

---
 rtl/sync_fifo_pkg.sv | 33 +++
 rtl/sync_fifo_ram.sv | 49 ++++
 rtl/sync_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: pointer compare helpers and
// the encoding of the overflow/underflow error pulses.
package sync_fifo_pkg;

    // Pointers are carried into the helpers zero-extended to this width.
    localparam int PTR_MAX_W = 32;

    // Error pulse encoding, one bit per error kind.
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

    // Empty when the full AW+1 bit pointers match.
    function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wr_ptr,
                                       input logic [PTR_MAX_W-1:0] rd_ptr,
                                       input int aw);
        logic [PTR_MAX_W-1:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return ((wr_ptr ^ rd_ptr) & mask) == '0;
    endfunction

    // Full when the wrap bits differ and the address bits match.
    function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr_ptr,
                                      input logic [PTR_MAX_W-1:0] rd_ptr,
                                      input int aw);
        logic [PTR_MAX_W-1:0] diff;
        logic [PTR_MAX_W-1:0] low_mask;
        diff     = wr_ptr ^ rd_ptr;
        low_mask = (32'd1 << aw) - 32'd1;
        return (((diff >> aw) & 32'd1) == 32'd1) && ((diff & low_mask) == '0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: DEPTH x DW array with one write
// port and one registered read port. The array itself is never reset; only
// the read data register is cleared so the FIFO output starts at zero.
module sync_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only touch the array on an accepted read, otherwise hold the last word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Registered read data, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with registered read data and one-cycle
// overflow/underflow pulses. Define SYNC_FIFO_LEVEL_EN to add the level_o
// occupancy output.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          full_o,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
`ifdef SYNC_FIFO_LEVEL_EN
    output logic [AW:0]   level_o,
`endif
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic [1:0]  err_q;
    logic [1:0]  err_d;
    logic        full;
    logic        empty;
    logic        wr_accept;
    logic        rd_accept;

    // Flags come straight from the registered pointers.
    always_comb begin
        full      = ptr_full(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q), AW);
        empty     = ptr_empty(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q), AW);
        wr_accept = wr_en_i && !full;
        rd_accept = rd_en_i && !empty;
    end

    // Pointer advance and error pulse generation for the coming edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = ERR_NONE;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en_i && full) begin
            err_d = err_d | ERR_OVERFLOW;
        end
        if (rd_en_i && empty) begin
            err_d = err_d | ERR_UNDERFLOW;
        end
    end

    // Pointer and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= ERR_NONE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data_o)
    );

    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = (err_q & ERR_OVERFLOW) != ERR_NONE;
    assign underflow_o = (err_q & ERR_UNDERFLOW) != ERR_NONE;

`ifdef SYNC_FIFO_LEVEL_EN
    assign level_o = wr_ptr_q - rd_ptr_q;
`endif

endmodule
